decode_hazard_scoreboard: RTL and testbench

Issue controller for the decode stage of the vectorial ASIP pipeline. It tracks in-flight writes to the 16-entry scalar register file and the 16-entry vector register file separately. It stalls the instruction sitting in decode when it would read or overwrite a register whose result has not yet reached writeback. It also counts stall cycles for performance measurement. It sits between the control unit outputs and the decode/execute pipeline register, and drives that register's hold and bubble controls.

---
 rtl/decode_hazard_scoreboard.sv | 61 ++++++
 tb/tb_decode_hazard_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_scoreboard.sv
// decode_hazard_scoreboard: decode-stage RAW/WAW hazard tracking with stall/issue control and stall counter
//   in : clk, rst_n (async low), dec_valid_i, vf_i, wreg_i, rmem_i, src2_i/src2_en_i, src3_i/src3_en_i, dest_i, flush_i
//   out: stall_o, issue_o (combinational), scalar_busy_o/vector_busy_o (per-register pending write), stall_cnt_o (saturating)
module decode_hazard_scoreboard #(
  parameter int LAT_ALU = 3,
  parameter int LAT_MEM = 4,
  parameter int CNT_W   = 3
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid_i,
  input  logic        vf_i,
  input  logic        wreg_i,
  input  logic        rmem_i,
  input  logic [3:0]  src2_i,
  input  logic        src2_en_i,
  input  logic [3:0]  src3_i,
  input  logic        src3_en_i,
  input  logic [3:0]  dest_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        issue_o,
  output logic [15:0] scalar_busy_o,
  output logic [15:0] vector_busy_o,
  output logic [15:0] stall_cnt_o
);
  logic [CNT_W-1:0] s_cnt [16];
  logic [CNT_W-1:0] v_cnt [16];
  logic [15:0] sel_busy;
  logic [CNT_W-1:0] lat;
  logic hazard;
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      scalar_busy_o[i] = |s_cnt[i];
      vector_busy_o[i] = |v_cnt[i];
    end
  end
  assign sel_busy = vf_i ? vector_busy_o : scalar_busy_o;
  assign hazard = dec_valid_i & ((src2_en_i & sel_busy[src2_i]) |
                                 (src3_en_i & sel_busy[src3_i]) |
                                 (wreg_i & sel_busy[dest_i]));
  assign stall_o = hazard & ~flush_i;
  assign issue_o = dec_valid_i & ~hazard & ~flush_i;
  assign lat = rmem_i ? CNT_W'(LAT_MEM) : CNT_W'(LAT_ALU);
  // A fresh load only ever lands on an idle entry (WAW blocks issue), so it simply overrides the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        s_cnt[i] <= '0;
        v_cnt[i] <= '0;
      end
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        s_cnt[i] <= (issue_o && wreg_i && !vf_i && dest_i == 4'(i)) ? lat : s_cnt[i] - CNT_W'(|s_cnt[i]);
        v_cnt[i] <= (issue_o && wreg_i &&  vf_i && dest_i == 4'(i)) ? lat : v_cnt[i] - CNT_W'(|v_cnt[i]);
      end
      stall_cnt_o <= stall_cnt_o + 16'(stall_o && stall_cnt_o != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// tb_decode_hazard_scoreboard: randomized + directed scoreboard bench against a ready-time reference model
`timescale 1ns/1ps
module tb_decode_hazard_scoreboard;
  localparam int LA = 3, LM = 4;
  typedef struct {
    logic        stall;
    logic        issue;
    logic [15:0] sb;
    logic [15:0] vb;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic dv = 0, vf = 0, wr = 0, rm = 0, e2 = 0, e3 = 0, fl = 0;
  logic [3:0] s2 = 0, s3 = 0, d = 0;
  logic stall, issue, sat_stall, sat_issue;
  logic [15:0] sb, vb, cnt, sat_sb, sat_vb, sat_cnt;
  int checks = 0, errors = 0;
  exp_t q[$];
  longint ready [2][16];
  longint cyc = 0;
  int mcnt = 0;
  always #5 clk = ~clk;
  decode_hazard_scoreboard #(.LAT_ALU(LA), .LAT_MEM(LM), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid_i(dv), .vf_i(vf), .wreg_i(wr), .rmem_i(rm),
    .src2_i(s2), .src2_en_i(e2), .src3_i(s3), .src3_en_i(e3), .dest_i(d), .flush_i(fl),
    .stall_o(stall), .issue_o(issue), .scalar_busy_o(sb), .vector_busy_o(vb), .stall_cnt_o(cnt));
  decode_hazard_scoreboard #(.LAT_ALU(3), .LAT_MEM(250), .CNT_W(8)) sat (
    .clk(clk), .rst_n(rst_n), .dec_valid_i(dv), .vf_i(vf), .wreg_i(wr), .rmem_i(rm),
    .src2_i(s2), .src2_en_i(e2), .src3_i(s3), .src3_en_i(e3), .dest_i(d), .flush_i(fl),
    .stall_o(sat_stall), .issue_o(sat_issue), .scalar_busy_o(sat_sb), .vector_busy_o(sat_vb), .stall_cnt_o(sat_cnt));
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall_o", 16'(stall), 16'(e.stall));
      chk("issue_o", 16'(issue), 16'(e.issue));
      chk("scalar_busy_o", sb, e.sb);
      chk("vector_busy_o", vb, e.vb);
      chk("stall_cnt_o", cnt, e.cnt);
    end
  end
  function automatic bit busy(input bit t, input logic [3:0] r);
    return ready[int'(t)][r] > cyc;
  endfunction
  function automatic logic [15:0] busy_vec(input bit t);
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = busy(t, 4'(r));
    return v;
  endfunction
  task automatic step(input bit v, f, w, m, input logic [3:0] a2, input bit x2,
                      input logic [3:0] a3, input bit x3, input logic [3:0] dd, input bit fx, output bit st);
    exp_t e;
    bit hz;
    dv = v; vf = f; wr = w; rm = m; s2 = a2; e2 = x2; s3 = a3; e3 = x3; d = dd; fl = fx;
    hz = v && ((x2 && busy(f, a2)) || (x3 && busy(f, a3)) || (w && busy(f, dd)));
    e.stall = hz && !fx;
    e.issue = v && !hz && !fx;
    e.sb = busy_vec(0);
    e.vb = busy_vec(1);
    e.cnt = 16'(mcnt);
    q.push_back(e);
    st = e.stall;
    @(posedge clk);
    #1;
    if (e.stall && mcnt < 65535) mcnt++;
    if (e.issue && w) ready[int'(f)][dd] = cyc + 1 + (m ? LM : LA);
    cyc++;
  endtask
  task automatic do_reset();
    exp_t e;
    rst_n = 0;
    #1;
    for (int t = 0; t < 2; t++) for (int r = 0; r < 16; r++) ready[t][r] = 0;
    mcnt = 0;
    e.stall = 0;
    e.issue = dv && !fl;
    e.sb = 0;
    e.vb = 0;
    e.cnt = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1;
  endtask
  task automatic hold_until_issue(input bit v, f, w, m, input logic [3:0] a2, input bit x2,
                                  input logic [3:0] a3, input bit x3, input logic [3:0] dd);
    bit st = 1;
    int n = 0;
    while (st && n < 20) begin
      step(v, f, w, m, a2, x2, a3, x3, dd, 0, st);
      n++;
    end
    if (st) begin
      checks++;
      errors++;
      $display("FAIL hold_bound act=stalled exp=issued within 20 cycles");
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bit st;
    bit hv, hf, hw, hm, hx2, hx3;
    logic [3:0] h2, h3, hd;
    @(posedge clk);
    #1;
    do_reset();
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, st);
    hold_until_issue(1, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    step(1, 1, 1, 1, 0, 0, 0, 0, 5, 0, st);
    step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, st);
    hold_until_issue(1, 1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 2, 0, st);
    step(1, 0, 1, 0, 0, 0, 2, 0, 3, 0, st);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    step(1, 0, 1, 0, 0, 0, 0, 0, 7, 0, st);
    hold_until_issue(1, 0, 1, 0, 0, 0, 0, 0, 7);
    step(1, 0, 1, 0, 0, 0, 0, 0, 4, 0, st);
    step(1, 0, 1, 0, 4, 1, 0, 0, 9, 1, st);
    step(1, 0, 1, 0, 4, 1, 0, 0, 9, 1, st);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, st);
    step(1, 0, 1, 0, 0, 0, 0, 0, 2, 0, st);
    step(1, 1, 1, 1, 0, 0, 0, 0, 3, 0, st);
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, st);
    do_reset();
    step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, st);
    st = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!st) begin
        hv = $urandom_range(0, 99) < 85;
        hf = $urandom_range(0, 1);
        hw = $urandom_range(0, 1);
        hm = $urandom_range(0, 1);
        h2 = 4'($urandom_range(0, 3));
        h3 = 4'($urandom_range(0, 3));
        hd = 4'($urandom_range(0, 3));
        hx2 = $urandom_range(0, 1);
        hx3 = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        st = 0;
      end else
        step(hv, hf, hw, hm, h2, hx2, h3, hx3, hd, $urandom_range(0, 99) < 8, st);
    end
    do_reset();
    dv = 1; vf = 0; wr = 1; rm = 1; s2 = 1; e2 = 1; s3 = 0; e3 = 0; d = 1; fl = 0;
    repeat (66000) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_cnt", sat_cnt, 16'hFFFF);
    repeat (600) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_cnt_hold", sat_cnt, 16'hFFFF);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
